// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared constants and types for the 8-to-3 handshake request encoder.
//   REQ_N       : number of request lines (8)
//   IDX_W       : width of an encoded index (3)
//   idx_t       : 3-bit request index
//   enc_state_t : grant FSM state (IDLE / HOLD)
//   idxToMask   : converts an index into a one-hot request mask
// Optional feature macro used by the encoder: ENCODER_8_3_HS_ROUND_ROBIN_EN
// ---------------------------------------------------------------------------
package encoder_pkg;

    localparam int REQ_N = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE,
        HOLD
    } enc_state_t;

    // One-hot mask of the request line selected by idx, used to clear the
    // granted pending bit when the consumer accepts it.
    function automatic logic [REQ_N-1:0] idxToMask(input idx_t idx);
        logic [REQ_N-1:0] mask;
        mask = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/encoder_8_3_hs_prio_find_8.sv
// ---------------------------------------------------------------------------
// prio_find_8
// Combinational circular priority finder. Scans vec_i downward starting at
// start_i (start_i, start_i-1, ..., 0, 7, ..., start_i+1) and reports the
// first set bit.
// Ports:
//   vec_i   [7:0] : candidate request vector
//   start_i [2:0] : index examined first
//   found_o       : at least one bit of vec_i is set
//   idx_o   [2:0] : index of the first set bit in scan order (0 if none)
// ---------------------------------------------------------------------------
module prio_find_8
    import encoder_pkg::*;
(
    input  logic [REQ_N-1:0] vec_i,
    input  idx_t             start_i,
    output logic             found_o,
    output idx_t             idx_o
);

    idx_t cand;

    // Walk the scan order from the far end back towards start_i so that the
    // last hit written is the one closest to start_i, i.e. the winner.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            cand = start_i - idx_t'(k);
            if (vec_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/encoder_8_3_hs.sv
// ---------------------------------------------------------------------------
// encoder_8_3_hs
// Registered 8-to-3 request encoder with a valid/ready output handshake.
// Rising edges on In are captured into a pending register; one pending index
// at a time is presented on Out and its bit is cleared when the consumer
// accepts it (valid && ready at a rising clock edge).
// Ports:
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous active-high reset
//   E             : capture enable for new request edges
//   In      [7:0] : request lines, a 0->1 transition is one request
//   ready         : consumer accepts Out when valid is high
//   Out     [2:0] : encoded index of the current grant
//   valid         : Out holds an unaccepted grant
//   pending [7:0] : current pending register
// Configuration macro: ENCODER_8_3_HS_ROUND_ROBIN_EN
//   defined   : rotating priority, scan starts just below the last grant
//   undefined : fixed priority, highest index wins
// ---------------------------------------------------------------------------
module encoder_8_3_hs
    import encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] In,
    input  logic       ready,
    output logic [2:0] Out,
    output logic       valid,
    output logic [7:0] pending
);

    logic [REQ_N-1:0] in_q;
    logic [REQ_N-1:0] pend_q;
    logic [REQ_N-1:0] pend_d;
    logic [REQ_N-1:0] setMask;
    logic [REQ_N-1:0] clrMask;
    logic [REQ_N-1:0] scanVec;
    enc_state_t       state_q;
    idx_t             out_q;
    logic             valid_q;
    logic             handshake;
    idx_t             scanStart;
    logic             found;
    idx_t             foundIdx;

`ifdef ENCODER_8_3_HS_ROUND_ROBIN_EN
    idx_t             last_q;

    // Rotating priority: start just below the previous grant so the line
    // that was just served is examined last. The 3-bit subtraction wraps
    // 0 back to 7, so the reset value of 0 starts the first scan at 7.
    always_comb begin
        scanStart = last_q - idx_t'(1);
    end
`else
    // Fixed priority: always begin the scan at the highest request line.
    always_comb begin
        scanStart = idx_t'(REQ_N - 1);
    end
`endif

    // Next pending value: clear the accepted grant, then OR in new edges so
    // a re-request on the granted line during its handshake is kept. While
    // in HOLD the next grant is chosen from this next value so back-to-back
    // grants see requests arriving in the handshake cycle; from IDLE only
    // the registered pending bits are eligible.
    always_comb begin
        handshake = (state_q == HOLD) && valid_q && ready;
        setMask   = E ? (In & ~in_q) : '0;
        clrMask   = handshake ? idxToMask(out_q) : '0;
        pend_d    = (pend_q & ~clrMask) | setMask;
        scanVec   = (state_q == HOLD) ? pend_d : pend_q;
    end

    prio_find_8 u_prio_find (
        .vec_i   (scanVec),
        .start_i (scanStart),
        .found_o (found),
        .idx_o   (foundIdx)
    );

    // Edge capture, pending register and the grant FSM. Out and valid are
    // registered and only move on an IDLE->HOLD transition or an accepted
    // handshake, so they stay stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
`ifdef ENCODER_8_3_HS_ROUND_ROBIN_EN
            last_q  <= '0;
`endif
        end else begin
            in_q   <= In;
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        out_q   <= foundIdx;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
`ifdef ENCODER_8_3_HS_ROUND_ROBIN_EN
                        last_q  <= foundIdx;
`endif
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        if (found) begin
                            out_q   <= foundIdx;
                            valid_q <= 1'b1;
`ifdef ENCODER_8_3_HS_ROUND_ROBIN_EN
                            last_q  <= foundIdx;
`endif
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Out     = out_q;
    assign valid   = valid_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_encoder_8_3_hs.sv
// ---------------------------------------------------------------------------
// tb_encoder_8_3_hs
// Directed self-checking bench for encoder_8_3_hs. Inputs are driven 1 ns
// after each rising edge and outputs are sampled at that same point.
// Macro honoured: ENCODER_8_3_HS_ROUND_ROBIN_EN (enables the rotation test).
// ---------------------------------------------------------------------------
module tb_encoder_8_3_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic       E;
    logic [7:0] In;
    logic       ready;
    logic [2:0] Out;
    logic       valid;
    logic [7:0] pending;

    int vectorsApplied = 0;
    int miscompares    = 0;
    int grantCount;

    encoder_8_3_hs dut (
        .clk     (clk),
        .rst     (rst),
        .E       (E),
        .In      (In),
        .ready   (ready),
        .Out     (Out),
        .valid   (valid),
        .pending (pending)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the request-side inputs.
    task automatic applyStimulus(input logic e, input logic [7:0] req, input logic rdy);
        E     = e;
        In    = req;
        ready = rdy;
    endtask

    // One comparison of an observed value against a hand-computed value.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorsApplied++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Synchronous reset for two cycles with idle inputs.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] rrExp [9];
        rrExp = '{3'd7, 3'd3, 3'd1, 3'd7, 3'd3, 3'd1, 3'd7, 3'd3, 3'd1};

        rst = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick(2);
        checkOutput("reset_valid", {7'b0, valid}, 8'h00);
        checkOutput("reset_out", {5'b0, Out}, 8'h00);
        checkOutput("reset_pending", pending, 8'h00);
        rst = 1'b0;

        // Single request on line 5 with a stalled consumer.
        applyStimulus(1'b1, 8'h20, 1'b0);
        tick();
        checkOutput("pulse5_pending", pending, 8'h20);
        checkOutput("pulse5_valid_early", {7'b0, valid}, 8'h00);
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("pulse5_out", {5'b0, Out}, 8'h05);
        checkOutput("pulse5_valid", {7'b0, valid}, 8'h01);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_out", {5'b0, Out}, 8'h05);
            checkOutput("stall_valid", {7'b0, valid}, 8'h01);
        end
        applyStimulus(1'b1, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("accept5_pending", pending, 8'h00);
        checkOutput("accept5_valid", {7'b0, valid}, 8'h00);

        // Two simultaneous requests served back to back.
        doReset();
        applyStimulus(1'b1, 8'h81, 1'b1);
        tick();
        checkOutput("dual_pending", pending, 8'h81);
        applyStimulus(1'b1, 8'h00, 1'b1);
        tick();
        checkOutput("dual_first_out", {5'b0, Out}, 8'h07);
        checkOutput("dual_first_valid", {7'b0, valid}, 8'h01);
        tick();
        checkOutput("dual_second_out", {5'b0, Out}, 8'h00);
        checkOutput("dual_second_valid", {7'b0, valid}, 8'h01);
        checkOutput("dual_second_pending", pending, 8'h01);
        tick();
        checkOutput("dual_done_valid", {7'b0, valid}, 8'h00);
        checkOutput("dual_done_pending", pending, 8'h00);

`ifdef ENCODER_8_3_HS_ROUND_ROBIN_EN
        // Lines 7, 3 and 1 re-request every other cycle; grants must rotate.
        doReset();
        applyStimulus(1'b1, 8'h8A, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            checkOutput("rr_order", {5'b0, Out}, {5'b0, rrExp[i]});
            checkOutput("rr_valid", {7'b0, valid}, 8'h01);
            applyStimulus(1'b1, (i % 2 == 0) ? 8'h8A : 8'h00, 1'b1);
            tick();
        end
`endif

        // Re-request on the granted line during its handshake cycle.
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("rereq_out", {5'b0, Out}, 8'h04);
        applyStimulus(1'b1, 8'h10, 1'b1);
        tick();
        checkOutput("rereq_pending", pending, 8'h10);
        checkOutput("rereq_out_again", {5'b0, Out}, 8'h04);
        checkOutput("rereq_valid_again", {7'b0, valid}, 8'h01);
        tick();
        checkOutput("rereq_done_pending", pending, 8'h00);
        checkOutput("rereq_done_valid", {7'b0, valid}, 8'h00);

        // Capture disabled: toggling lines must not create requests.
        doReset();
        applyStimulus(1'b0, 8'hFF, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'hFF, 1'b0);
        tick(2);
        checkOutput("disabled_pending", pending, 8'h00);
        checkOutput("disabled_valid", {7'b0, valid}, 8'h00);

        // Line 0 held high through reset yields exactly one grant.
        rst = 1'b1;
        applyStimulus(1'b1, 8'h01, 1'b1);
        tick(2);
        rst = 1'b0;
        grantCount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid === 1'b1) begin
                grantCount++;
                checkOutput("held_grant_out", {5'b0, Out}, 8'h00);
            end
        end
        checkOutput("held_grant_count", 8'(grantCount), 8'h01);

        // Reset while a grant is outstanding and two bits are pending.
        doReset();
        applyStimulus(1'b1, 8'h0C, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("prerst_out", {5'b0, Out}, 8'h03);
        checkOutput("prerst_valid", {7'b0, valid}, 8'h01);
        checkOutput("prerst_pending", pending, 8'h0C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_valid", {7'b0, valid}, 8'h00);
        checkOutput("midrst_out", {5'b0, Out}, 8'h00);
        checkOutput("midrst_pending", pending, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/encoder_8_3_hs.md
# encoder_8_3_hs

Registered 8-to-3 request encoder with valid/ready output handshake, the encoding counterpart of the 3-to-8 decoder. Rising edges on eight request lines are captured into a pending register; the block presents one pending index at a time on `Out` and clears that bit once the consumer accepts it. It sits between asynchronous-style request sources (buttons, decoded strobes) and a single consumer that needs a binary index.

## Interface
- Parameters: none. Widths are fixed at 8 requests to a 3-bit index; constants live in the package.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `E` input 1: capture enable. When low, new request edges are ignored.
- `In` input 8: request lines; a 0→1 transition is one request.
- `ready` input 1: consumer accepts `Out` when `valid && ready` at a rising edge.
- `Out` output 3: encoded index of the granted request.
- `valid` output 1: `Out` holds an unaccepted grant.
- `pending` output 8: current pending register, for observation.

## Operation
- Edge capture:
  - `in_q` registers `In` every cycle.
  - Bit i is set in `pend` when `E && In[i] && !in_q[i]`.
- FSM states: IDLE and HOLD.
- IDLE:
  - If `pend != 0`, load `Out` with the selected index, assert `valid`, and go to HOLD.
  - Otherwise stay in IDLE with `valid = 0`.
- HOLD:
  - `Out` and `valid` stay stable until the handshake.
  - On `valid && ready`, clear `pend[Out]`.
  - If any other pending bit remains (including ones set this same cycle), load the next selected index, keep `valid = 1`, and stay in HOLD (back-to-back grants).
  - Otherwise deassert `valid` and return to IDLE.
- Selection with fixed priority: the highest set index wins (bit 7 first).
- Simultaneous set and clear of the same bit in one cycle: set wins, so the bit remains pending. A re-request on the granted line during its handshake cycle is never lost.
- A repeated edge on an already-pending bit merges into that bit. There is no counting.
- `E` gates capture only. Bits already pending continue to be served while `E = 0`.
- Reset values: `pend = 0`, `in_q = 0`, `Out = 0`, `valid = 0`, state IDLE, `last = 0`.
  - Because `in_q` resets to 0, a line held high through reset produces exactly one request after reset if `E = 1`.
- Reset asserted mid-operation discards all pending requests and any outstanding grant on that edge.

## Timing
- Latency: an edge sampled at clock edge k sets `pend` after k. From IDLE, `valid` and `Out` are visible after edge k+1, so the latency is 2 cycles.
- Throughput: with `ready` held high and multiple bits pending, one grant per cycle.
- `Out` changes only on an IDLE→HOLD transition or on a completed handshake. It never changes while `valid && !ready`.
- `pending` reflects the register value, not the next-state value.

## Configuration
- Macro: `ENCODER_8_3_HS_ROUND_ROBIN_EN`.
- Defined:
  - A rotating pointer `last` records each granted index.
  - Selection scans downward from `(last − 1) mod 8`, wrapping from 0 to 7.
  - `last` resets to 0, so the first scan starts at 7 and matches fixed priority until the first grant.
- Undefined:
  - Fixed priority, highest index wins.
  - `last` is not implemented.
- Ports and timing are identical in both builds.

## Structure
- Package `encoder_pkg` holds:
  - `REQ_N = 8` and `IDX_W = 3`.
  - `typedef enum logic {IDLE, HOLD} enc_state_t`.
  - The type `idx_t` for 3-bit indices.
- One sub-module, `prio_find_8`: combinational. It takes an 8-bit vector and a 3-bit start index, and returns `found` plus `idx`, the first set bit scanning downward from the start with wrap.
  - The fixed-priority build ties the start to 7.
- The top level contains the edge capture, the pending register, the FSM and `last`.

## Test plan
- Reset, then pulse `In = 8'h20` with `E = 1` and `ready = 0`: after 2 cycles `Out = 5` and `valid = 1`, and both stay unchanged for 10 cycles; raising `ready` for one cycle clears `pending` to 0 and `valid` to 0.
- Set `In = 8'h81` in one cycle with `ready = 1`:
  - Fixed build: `Out = 7`, then `Out = 0` on the next cycle, then `valid = 0`.
  - Round-robin build: same order.
- Round-robin build only: keep bits 7, 3 and 1 re-requesting continuously. The grant order is 7, 3, 1, 7, 3, …; no index is granted twice in a row while others are pending.
- During HOLD with `Out = 4`, drive a new 0→1 edge on `In[4]` in the same cycle as `ready = 1`: `pending[4]` remains 1 and `Out = 4` is granted again on the next cycle.
- Hold `E = 0` and toggle `In = 8'hFF`: `pending` stays 0 and `valid` stays 0. Hold `In = 8'h01` high through `rst` with `E = 1`: exactly one grant of index 0 follows.
- Assert `rst` while `valid = 1` and `pending = 8'h0C`: on the next cycle `valid = 0`, `Out = 0` and `pending = 0`.
